// File: rtl/alu_instr_idfr_pipe_pkg.sv
// Shared decode constants and instruction id codes for the ALU identifier.
// Ids for the M-extension exist always; RV_M_EXT_EN only decides legality.
package alu_instr_idfr_pipe_pkg;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [5:0] F6_BASE   = 6'b000000;
  localparam logic [5:0] F6_ALT    = 6'b010000;

  localparam int INST_ID_LEN = 6;
  typedef logic [INST_ID_LEN-1:0] inst_id_t;

  localparam inst_id_t NONE_ID   = 6'd0;
  localparam inst_id_t ADDI_ID   = 6'd1;
  localparam inst_id_t SLTI_ID   = 6'd2;
  localparam inst_id_t SLTIU_ID  = 6'd3;
  localparam inst_id_t XORI_ID   = 6'd4;
  localparam inst_id_t ORI_ID    = 6'd5;
  localparam inst_id_t ANDI_ID   = 6'd6;
  localparam inst_id_t SLLI_ID   = 6'd7;
  localparam inst_id_t SRLI_ID   = 6'd8;
  localparam inst_id_t SRAI_ID   = 6'd9;
  localparam inst_id_t ADD_ID    = 6'd10;
  localparam inst_id_t SUB_ID    = 6'd11;
  localparam inst_id_t SLL_ID    = 6'd12;
  localparam inst_id_t SLT_ID    = 6'd13;
  localparam inst_id_t SLTU_ID   = 6'd14;
  localparam inst_id_t XOR_ID    = 6'd15;
  localparam inst_id_t SRL_ID    = 6'd16;
  localparam inst_id_t SRA_ID    = 6'd17;
  localparam inst_id_t OR_ID     = 6'd18;
  localparam inst_id_t AND_ID    = 6'd19;
  localparam inst_id_t ADDIW_ID  = 6'd20;
  localparam inst_id_t SLLIW_ID  = 6'd21;
  localparam inst_id_t SRLIW_ID  = 6'd22;
  localparam inst_id_t SRAIW_ID  = 6'd23;
  localparam inst_id_t ADDW_ID   = 6'd24;
  localparam inst_id_t SUBW_ID   = 6'd25;
  localparam inst_id_t SLLW_ID   = 6'd26;
  localparam inst_id_t SRLW_ID   = 6'd27;
  localparam inst_id_t SRAW_ID   = 6'd28;
  localparam inst_id_t MUL_ID    = 6'd29;
  localparam inst_id_t MULH_ID   = 6'd30;
  localparam inst_id_t MULHSU_ID = 6'd31;
  localparam inst_id_t MULHU_ID  = 6'd32;
  localparam inst_id_t DIV_ID    = 6'd33;
  localparam inst_id_t DIVU_ID   = 6'd34;
  localparam inst_id_t REM_ID    = 6'd35;
  localparam inst_id_t REMU_ID   = 6'd36;
  localparam inst_id_t MULW_ID   = 6'd37;
  localparam inst_id_t DIVW_ID   = 6'd38;
  localparam inst_id_t DIVUW_ID  = 6'd39;
  localparam inst_id_t REMW_ID   = 6'd40;
  localparam inst_id_t REMUW_ID  = 6'd41;

  localparam logic CHIP_ENABLE = 1'b1;

  function automatic inst_id_t op_id(input logic [2:0] f3);
    inst_id_t r;
    unique case (f3)
      F3_ADD:  r = ADD_ID;
      F3_SLL:  r = SLL_ID;
      F3_SLT:  r = SLT_ID;
      F3_SLTU: r = SLTU_ID;
      F3_XOR:  r = XOR_ID;
      F3_SR:   r = SRL_ID;
      F3_OR:   r = OR_ID;
      default: r = AND_ID;
    endcase
    return r;
  endfunction

  function automatic inst_id_t mul_id(input logic [2:0] f3);
    inst_id_t r;
    unique case (f3)
      3'b000:  r = MUL_ID;
      3'b001:  r = MULH_ID;
      3'b010:  r = MULHSU_ID;
      3'b011:  r = MULHU_ID;
      3'b100:  r = DIV_ID;
      3'b101:  r = DIVU_ID;
      3'b110:  r = REM_ID;
      default: r = REMU_ID;
    endcase
    return r;
  endfunction

  // RV64 W-form M ops have no MULH* variants
  function automatic inst_id_t mulw_id(input logic [2:0] f3);
    inst_id_t r;
    unique case (f3)
      3'b000:  r = MULW_ID;
      3'b100:  r = DIVW_ID;
      3'b101:  r = DIVUW_ID;
      3'b110:  r = REMW_ID;
      3'b111:  r = REMUW_ID;
      default: r = NONE_ID;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_instr_idfr_pipe_class.sv
// Combinational classifier: raw instruction -> id, immediate, illegal.
// RV_M_EXT_EN makes the MUL/DIV encodings legal.
module alu_instr_class
  import alu_instr_idfr_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]            instr,
  output logic [INST_ID_LEN-1:0] id,
  output logic [XLEN-1:0]        imm,
  output logic                   illegal
);

  localparam bit RV64 = (XLEN == 64);
  localparam int SH_W = RV64 ? 6 : 5;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [5:0]      f6;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] sh_imm;
  logic [XLEN-1:0] shw_imm;
  logic            sh_base;
  logic            sh_alt;
  logic            in_class;
  inst_id_t        id_c;
  logic [XLEN-1:0] imm_c;
  logic            unused_bits;

  assign opc     = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign f6      = instr[31:26];
  assign i_imm   = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign sh_imm  = XLEN'(instr[20 +: SH_W]);
  assign shw_imm = XLEN'(instr[24:20]);
  assign sh_base = RV64 ? (f6 == F6_BASE) : (f7 == F7_BASE);
  assign sh_alt  = RV64 ? (f6 == F6_ALT) : (f7 == F7_ALT);

  assign unused_bits = ^{instr[19:15], instr[11:7]};

  always_comb begin
    in_class = 1'b0;
    id_c     = NONE_ID;
    imm_c    = '0;
    unique case (opc)
      OPC_OP_IMM: begin
        in_class = 1'b1;
        unique case (f3)
          F3_ADD:  begin id_c = ADDI_ID;  imm_c = i_imm; end
          F3_SLT:  begin id_c = SLTI_ID;  imm_c = i_imm; end
          F3_SLTU: begin id_c = SLTIU_ID; imm_c = i_imm; end
          F3_XOR:  begin id_c = XORI_ID;  imm_c = i_imm; end
          F3_OR:   begin id_c = ORI_ID;   imm_c = i_imm; end
          F3_AND:  begin id_c = ANDI_ID;  imm_c = i_imm; end
          F3_SLL: begin
            if (sh_base) begin
              id_c  = SLLI_ID;
              imm_c = sh_imm;
            end
          end
          default: begin
            if (sh_base) begin
              id_c  = SRLI_ID;
              imm_c = sh_imm;
            end else if (sh_alt) begin
              id_c  = SRAI_ID;
              imm_c = sh_imm;
            end
          end
        endcase
      end
      OPC_OP: begin
        in_class = 1'b1;
        unique case (f7)
          F7_BASE: id_c = op_id(f3);
          F7_ALT: begin
            if (f3 == F3_ADD)     id_c = SUB_ID;
            else if (f3 == F3_SR) id_c = SRA_ID;
          end
`ifdef RV_M_EXT_EN
          F7_MULDIV: id_c = mul_id(f3);
`endif
          default: ;
        endcase
      end
      OPC_OP_IMM_32: begin
        in_class = 1'b1;
        if (RV64) begin
          unique case (f3)
            F3_ADD: begin
              id_c  = ADDIW_ID;
              imm_c = i_imm;
            end
            F3_SLL: begin
              if (f7 == F7_BASE) begin
                id_c  = SLLIW_ID;
                imm_c = shw_imm;
              end
            end
            F3_SR: begin
              if (f7 == F7_BASE) begin
                id_c  = SRLIW_ID;
                imm_c = shw_imm;
              end else if (f7 == F7_ALT) begin
                id_c  = SRAIW_ID;
                imm_c = shw_imm;
              end
            end
            default: ;
          endcase
        end
      end
      OPC_OP_32: begin
        in_class = 1'b1;
        if (RV64) begin
          unique case (f7)
            F7_BASE: begin
              if (f3 == F3_ADD)      id_c = ADDW_ID;
              else if (f3 == F3_SLL) id_c = SLLW_ID;
              else if (f3 == F3_SR)  id_c = SRLW_ID;
            end
            F7_ALT: begin
              if (f3 == F3_ADD)     id_c = SUBW_ID;
              else if (f3 == F3_SR) id_c = SRAW_ID;
            end
`ifdef RV_M_EXT_EN
            F7_MULDIV: id_c = mulw_id(f3);
`endif
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // an in-class opcode with no matching rule is illegal; imm stays 0
  assign illegal = in_class && (id_c == NONE_ID);
  assign id      = id_c;
  assign imm     = imm_c;

endmodule

// File: rtl/alu_instr_idfr_pipe.sv
// Decode-stage ALU identifier: skid buffer, output register, illegal counter.
// Define RV_M_EXT_EN to accept M-extension encodings.
module alu_instr_idfr_pipe
  import alu_instr_idfr_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 8,
  parameter int ILL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INST_ID_LEN-1:0] out_instr_id,
  output logic [XLEN-1:0]        out_imm,
  output logic                   out_illegal,
  output logic [TAG_W-1:0]       out_tag,
  output logic [ILL_CNT_W-1:0]   ill_cnt
);

  typedef struct packed {
    inst_id_t         id;
    logic [XLEN-1:0]  imm;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t ENTRY_RST = '{id: NONE_ID, imm: '0, ill: 1'b0, tag: '0};

  inst_id_t        c_id;
  logic [XLEN-1:0] c_imm;
  logic            c_ill;
  entry_t          c_entry;
  entry_t          out_q;
  entry_t          skid_q;
  logic            out_v;
  logic            skid_v;
  logic            accept;
  logic            out_fire;
  logic            out_free;
  logic [ILL_CNT_W-1:0] cnt_q;

  alu_instr_class #(
    .XLEN(XLEN)
  ) u_class (
    .instr   (in_instr),
    .id      (c_id),
    .imm     (c_imm),
    .illegal (c_ill)
  );

  always_comb begin
    c_entry     = ENTRY_RST;
    c_entry.id  = c_id;
    c_entry.imm = c_imm;
    c_entry.ill = c_ill;
    c_entry.tag = in_tag;
  end

  assign accept   = CHIP_ENABLE && in_valid && !skid_v && !flush;
  assign out_fire = out_v && out_ready;
  assign out_free = !out_v || out_ready;

  // skid only fills behind a stalled output, so skid_v implies out_v
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= ENTRY_RST;
      skid_q <= ENTRY_RST;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (out_free) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        out_v <= accept;
        if (accept) out_q <= c_entry;
      end
    end else if (accept) begin
      skid_q <= c_entry;
      skid_v <= 1'b1;
    end
  end

  // counts at downstream handoff, even in a flush cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_fire && out_q.ill && (cnt_q != '1)) begin
      cnt_q <= cnt_q + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready     = !skid_v;
  assign out_valid    = out_v;
  assign out_instr_id = out_q.id;
  assign out_imm      = out_q.imm;
  assign out_illegal  = out_q.ill;
  assign out_tag      = out_q.tag;
  assign ill_cnt      = cnt_q;

endmodule

// File: tb/tb_alu_instr_idfr_pipe.sv
// Self-checking bench for alu_instr_idfr_pipe (XLEN=32).
// Scoreboard monitor plus directed and randomized scenario tasks.
module tb_alu_instr_idfr_pipe;
  import alu_instr_idfr_pipe_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 8;
  localparam int ILL_W = 8;
`ifdef RV_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  typedef struct packed {
    logic [INST_ID_LEN-1:0] id;
    logic [XLEN-1:0]        imm;
    logic                   ill;
    logic [TAG_W-1:0]       tag;
  } exp_t;

  localparam inst_id_t OPI_TAB [8] = '{ADDI_ID, NONE_ID, SLTI_ID, SLTIU_ID,
                                       XORI_ID, NONE_ID, ORI_ID, ANDI_ID};
  localparam inst_id_t OP_TAB  [8] = '{ADD_ID, SLL_ID, SLT_ID, SLTU_ID,
                                       XOR_ID, SRL_ID, OR_ID, AND_ID};
  localparam inst_id_t M_TAB   [8] = '{MUL_ID, MULH_ID, MULHSU_ID, MULHU_ID,
                                       DIV_ID, DIVU_ID, REM_ID, REMU_ID};
  localparam inst_id_t MW_TAB  [8] = '{MULW_ID, NONE_ID, NONE_ID, NONE_ID,
                                       DIVW_ID, DIVUW_ID, REMW_ID, REMUW_ID};

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [31:0]            in_instr = '0;
  logic [TAG_W-1:0]       in_tag = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [INST_ID_LEN-1:0] out_instr_id;
  logic [XLEN-1:0]        out_imm;
  logic                   out_illegal;
  logic [TAG_W-1:0]       out_tag;
  logic [ILL_W-1:0]       ill_cnt;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [ILL_W-1:0] exp_cnt = '0;

  alu_instr_idfr_pipe #(
    .XLEN(XLEN), .TAG_W(TAG_W), .ILL_CNT_W(ILL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr_id(out_instr_id), .out_imm(out_imm),
    .out_illegal(out_illegal), .out_tag(out_tag),
    .ill_cnt(ill_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] i, input logic [TAG_W-1:0] tag);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [11:0] hi12, upper, sra_key, shamt;
    logic w;
    int sw;
    opc = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    hi12 = i[31:20];
    e.id = NONE_ID;
    e.imm = '0;
    e.ill = 1'b0;
    e.tag = tag;
    w = (opc == OPC_OP_IMM_32) || (opc == OPC_OP_32);
    if (!(opc inside {OPC_OP_IMM, OPC_OP, OPC_OP_IMM_32, OPC_OP_32})) return e;
    if (w && XLEN != 64) begin
      e.ill = 1'b1;
      return e;
    end
    if (opc == OPC_OP_IMM || opc == OPC_OP_IMM_32) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        sw = (w || XLEN == 32) ? 5 : 6;
        upper = hi12 >> sw;
        sra_key = 12'h400 >> sw;
        shamt = hi12 & ((12'd1 << sw) - 12'd1);
        if (upper == 12'd0)
          e.id = (f3 == 3'd1) ? (w ? SLLIW_ID : SLLI_ID) : (w ? SRLIW_ID : SRLI_ID);
        else if (f3 == 3'd5 && upper == sra_key)
          e.id = w ? SRAIW_ID : SRAI_ID;
        e.imm = XLEN'(shamt);
      end else begin
        e.id = w ? ((f3 == 3'd0) ? ADDIW_ID : NONE_ID) : OPI_TAB[f3];
        e.imm = {{(XLEN-12){hi12[11]}}, hi12};
      end
    end else begin
      if (f7 == 7'h00)
        e.id = w ? ((f3 == 0) ? ADDW_ID : (f3 == 1) ? SLLW_ID : (f3 == 5) ? SRLW_ID : NONE_ID)
                 : OP_TAB[f3];
      else if (f7 == 7'h20)
        e.id = (f3 == 0) ? (w ? SUBW_ID : SUB_ID) : (f3 == 5) ? (w ? SRAW_ID : SRA_ID) : NONE_ID;
      else if (f7 == 7'h01 && M_EN)
        e.id = w ? MW_TAB[f3] : M_TAB[f3];
    end
    if (e.id == NONE_ID) begin
      e.ill = 1'b1;
      e.imm = '0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k, j;
    r = $urandom;
    k = $urandom_range(0, 7);
    j = $urandom_range(0, 4);
    case (k)
      0, 1: r[6:0] = OPC_OP_IMM;
      2, 3: r[6:0] = OPC_OP;
      4: r[6:0] = OPC_OP_IMM_32;
      5: r[6:0] = OPC_OP_32;
      default: ;
    endcase
    case (j)
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      3: r[31:25] = {6'h00, 1'b1};
      default: ;
    endcase
    return r;
  endfunction

  // scoreboard: state is stable at the negedge, so predict the next edge here
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_cnt = '0;
    end else begin
      exp_t f;
      bit fire, acc;
      checks++;
      if (out_valid !== (q.size() > 0)) begin
        errors++;
        $display("FAIL mon_out_valid got %0b want %0b", out_valid, q.size() > 0);
      end
      checks++;
      if (in_ready !== (q.size() < 2)) begin
        errors++;
        $display("FAIL mon_in_ready got %0b want %0b", in_ready, q.size() < 2);
      end
      checks++;
      if (ill_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL mon_ill_cnt got %0d want %0d", ill_cnt, exp_cnt);
      end
      if (q.size() > 0) begin
        f = q[0];
        checks++;
        if ({out_instr_id, out_imm, out_illegal, out_tag} !== f) begin
          errors++;
          $display("FAIL mon_data got id=%0d imm=%h ill=%0b tag=%h want id=%0d imm=%h ill=%0b tag=%h",
                   out_instr_id, out_imm, out_illegal, out_tag, f.id, f.imm, f.ill, f.tag);
        end
      end
      fire = (q.size() > 0) && out_ready;
      acc = in_valid && (q.size() < 2) && !flush;
      if (fire) begin
        f = q.pop_front();
        if (f.ill && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      end
      if (flush) q.delete();
      else if (acc) q.push_back(model(in_instr, in_tag));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs got v=%0b r=%0b want 0 1", out_valid, in_ready);
    end
    checks++;
    if (out_instr_id !== NONE_ID || out_imm !== '0 || out_illegal !== 1'b0 ||
        out_tag !== '0 || ill_cnt !== '0) begin
      errors++;
      $display("FAIL reset_data got id=%0d imm=%h ill=%0b tag=%h cnt=%0d want zeros",
               out_instr_id, out_imm, out_illegal, out_tag, ill_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [INST_ID_LEN-1:0] w_id;
    logic [XLEN-1:0] w_imm;
    logic w_ill;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hFFF00093;
    in_tag = 8'h11;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_instr_id !== ADDI_ID || out_imm !== 32'hFFFFFFFF ||
        out_illegal !== 1'b0 || out_tag !== 8'h11) begin
      errors++;
      $display("FAIL addi got v=%0b id=%0d imm=%h ill=%0b want 1 %0d ffffffff 0",
               out_valid, out_instr_id, out_imm, out_illegal, ADDI_ID);
    end
    tick();
    in_valid = 1'b1;
    in_instr = 32'h4030D093;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_instr_id !== SRAI_ID || out_imm !== 32'd3 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL srai got id=%0d imm=%h ill=%0b want %0d 3 0",
               out_instr_id, out_imm, out_illegal, SRAI_ID);
    end
    tick();
    w_id = (XLEN == 64) ? SLLI_ID : NONE_ID;
    w_imm = (XLEN == 64) ? 33 : 0;
    w_ill = (XLEN == 64) ? 1'b0 : 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h02109093;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_instr_id !== w_id || out_imm !== w_imm || out_illegal !== w_ill || ill_cnt !== '0) begin
      errors++;
      $display("FAIL slli33 got id=%0d imm=%h ill=%0b cnt=%0d want %0d %h %0b 0",
               out_instr_id, out_imm, out_illegal, ill_cnt, w_id, w_imm, w_ill);
    end
    tick();
    checks++;
    if (ill_cnt !== ILL_W'(w_ill)) begin
      errors++;
      $display("FAIL ill_cnt_inc got %0d want %0d", ill_cnt, w_ill);
    end
    w_id = M_EN ? MUL_ID : NONE_ID;
    w_ill = !M_EN;
    in_valid = 1'b1;
    in_instr = 32'h02208033;
    tick();
    in_instr = 32'h0000003B;
    checks++;
    if (out_instr_id !== w_id || out_illegal !== w_ill) begin
      errors++;
      $display("FAIL mul got id=%0d ill=%0b want %0d %0b", out_instr_id, out_illegal, w_id, w_ill);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_instr_id !== NONE_ID || out_illegal !== 1'b1) begin
      errors++;
      $display("FAIL addw_rv32 got id=%0d ill=%0b want 0 1", out_instr_id, out_illegal);
    end
    in_instr = 32'h00000037;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_instr_id !== NONE_ID || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL lui_other got id=%0d ill=%0b want 0 0", out_instr_id, out_illegal);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00500093;
    in_tag = 8'd1;
    tick();
    in_tag = 8'd2;
    in_instr = 32'h00A00113;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_ready got %0b want 1", in_ready);
    end
    tick();
    in_tag = 8'd3;
    in_instr = 32'h002081B3;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_third_ready got %0b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 8'd1) begin
      errors++;
      $display("FAIL b2b_hold got v=%0b tag=%0d want 1 1", out_valid, out_tag);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_tag !== 8'd2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got tag=%0d rdy=%0b want 2 1", out_tag, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 8'd3 || out_instr_id !== ADD_ID) begin
      errors++;
      $display("FAIL b2b_third got v=%0b tag=%0d id=%0d want 1 3 %0d",
               out_valid, out_tag, out_instr_id, ADD_ID);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got %0b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00100093;
    in_tag = 8'd4;
    tick();
    in_tag = 8'd5;
    tick();
    in_tag = 8'd6;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush got v=%0b r=%0b want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop got v=%0b tag=%0d want 0", out_valid, out_tag);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = rand_instr();
      in_tag = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_saturate_and_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0000003B;
    repeat ((1 << ILL_W) + 3) tick();
    checks++;
    if (ill_cnt !== '1) begin
      errors++;
      $display("FAIL ill_sat got %0d want %0d", ill_cnt, (1 << ILL_W) - 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr_id !== NONE_ID ||
        out_imm !== '0 || out_illegal !== 1'b0 || out_tag !== '0 || ill_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset got v=%0b r=%0b id=%0d ill=%0b cnt=%0d want 0 1 0 0 0",
               out_valid, in_ready, out_instr_id, out_illegal, ill_cnt);
    end
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || ill_cnt !== '0) begin
      errors++;
      $display("FAIL post_reset got v=%0b cnt=%0d want 0 0", out_valid, ill_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_random();
    test_saturate_and_reset();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
